// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic job scheduler.
package systolic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_OUT  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // mac_en hold time: SIZE load beats plus the skew for data to cross the array.
  function automatic int run_cycles(input int size);
    return 3 * size - 2;
  endfunction

  function automatic int width_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NREQ_DEF  = 2;
  localparam int SEL_W_DEF = width_min1(NREQ_DEF);

endpackage

// File: rtl/systolic_rr_arb.sv
// Combinational round-robin pick: first set req bit at or above ptr, with wrap.
module systolic_rr_arb
  import systolic_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  // Scan from the farthest offset down so the closest requester wins last.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      if (req[(int'(ptr) + off) % NREQ]) begin
        grant                               = '0;
        grant[(int'(ptr) + off) % NREQ]     = 1'b1;
        idx                                 = SEL_W'((int'(ptr) + off) % NREQ);
        any                                 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/systolic_job_sched.sv
// Shares one systolic MAC array between NREQ requesters: grant, load, run, drain.
// state | meaning
// IDLE  | waiting for a request, pointer selects search start
// LOAD  | accepting SIZE x/w row pairs from the granted requester
// RUN   | mac_en held RUN_CYCLES cycles
// OUT   | draining SIZE result rows under out_rdy backpressure
// DONE  | job_done pulse, release grant, advance pointer
module systolic_job_sched
  import systolic_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int SIZE       = 4,
  parameter int RUN_CYCLES = run_cycles(SIZE)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREQ-1:0]               req_val,
  output logic [NREQ-1:0]               req_grant,
  output logic [width_min1(NREQ)-1:0]   sel,
  input  logic                          load_val,
  output logic                          load_rdy,
  output logic                          arr_load_en,
  output logic                          arr_acc_clr,
  output logic                          arr_mac_en,
  output logic                          out_val,
  input  logic                          out_rdy,
  output logic [width_min1(SIZE)-1:0]   out_row,
  output logic                          job_done,
  output logic                          busy,
  output logic [2:0]                    trace_state
);

  localparam int SEL_W = width_min1(NREQ);
  localparam int ROW_W = width_min1(SIZE);
  localparam int CW    = $clog2(RUN_CYCLES + 1);

  state_t           state_q, state_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             clr_q, clr_d;

  logic [NREQ-1:0]  arb_grant;
  logic [SEL_W-1:0] arb_idx;
  logic             arb_any;

  systolic_rr_arb #(
    .NREQ  (NREQ),
    .SEL_W (SEL_W)
  ) u_arb (
    .req   (req_val),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    clr_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          grant_d = arb_grant;
          sel_d   = arb_idx;
          clr_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (load_val) begin
          if (cnt_q == CW'(SIZE - 1)) begin
            cnt_d   = '0;
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_RUN: begin
        if (cnt_q == CW'(RUN_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_OUT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_OUT: begin
        if (out_rdy) begin
          if (cnt_q == CW'(SIZE - 1)) begin
            cnt_d   = '0;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_DONE: begin
        grant_d = '0;
        ptr_d   = (sel_q == SEL_W'(NREQ - 1)) ? '0 : sel_q + SEL_W'(1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Only the load handshake is combinational; everything else decodes flops.
  assign load_rdy    = (state_q == ST_LOAD);
  assign arr_load_en = load_rdy & load_val;
  assign req_grant   = grant_q;
  assign sel         = sel_q;
  assign arr_acc_clr = clr_q;
  assign arr_mac_en  = (state_q == ST_RUN);
  assign out_val     = (state_q == ST_OUT);
  assign out_row     = (state_q == ST_OUT) ? cnt_q[ROW_W-1:0] : '0;
  assign job_done    = (state_q == ST_DONE);
  assign busy        = (state_q != ST_IDLE);
  assign trace_state = state_q;

endmodule

// File: tb/tb_systolic_job_sched.sv
// Directed self-checking bench for systolic_job_sched (NREQ=2, SIZE=4).
module tb_systolic_job_sched;

  localparam int NREQ = 2;
  localparam int SIZE = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NREQ-1:0]  req_val;
  logic [NREQ-1:0]  req_grant;
  logic [0:0]       sel;
  logic             load_val;
  logic             load_rdy;
  logic             arr_load_en;
  logic             arr_acc_clr;
  logic             arr_mac_en;
  logic             out_val;
  logic             out_rdy;
  logic [1:0]       out_row;
  logic             job_done;
  logic             busy;
  logic [2:0]       trace_state;

  int checks = 0;
  int errors = 0;

  systolic_job_sched #(
    .NREQ (NREQ),
    .SIZE (SIZE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_val     (req_val),
    .req_grant   (req_grant),
    .sel         (sel),
    .load_val    (load_val),
    .load_rdy    (load_rdy),
    .arr_load_en (arr_load_en),
    .arr_acc_clr (arr_acc_clr),
    .arr_mac_en  (arr_mac_en),
    .out_val     (out_val),
    .out_rdy     (out_rdy),
    .out_row     (out_row),
    .job_done    (job_done),
    .busy        (busy),
    .trace_state (trace_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, 32'({req_grant, sel, arr_acc_clr, arr_mac_en, out_val, out_row,
                  job_done, busy, trace_state, load_rdy, arr_load_en}), 32'd0);
  endtask

  task automatic finish_from_run(input logic [1:0] g, input int stall_row);
    int n;
    n = 0;
    while (trace_state == 3'd2 && n < 100) begin
      n++;
      tick();
    end
    chk("mac_cycles", n, 10);
    for (int r = 0; r < SIZE; r++) begin
      chk("out_state", 32'(trace_state), 32'd3);
      chk("out_val", 32'(out_val), 32'd1);
      chk("out_row", 32'(out_row), r);
      chk("out_grant", 32'(req_grant), 32'(g));
      if (r == stall_row) begin
        out_rdy = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick();
          chk("stall_val", 32'(out_val), 32'd1);
          chk("stall_row", 32'(out_row), r);
        end
        out_rdy = 1'b1;
      end
      tick();
    end
    chk("done_state", 32'(trace_state), 32'd4);
    chk("done_pulse", 32'(job_done), 32'd1);
    chk("done_grant", 32'(req_grant), 32'(g));
    tick();
    chk("idle_after", 32'({trace_state, busy, job_done, req_grant}), 32'd0);
  endtask

  task automatic do_job(input logic [1:0] g, input int sel_exp,
                        input logic [1:0] req_after, input int stall_row);
    int loads;
    int cyc;
    tick();
    chk("grant", 32'(req_grant), 32'(g));
    chk("sel", 32'(sel), sel_exp);
    chk("load_state", 32'(trace_state), 32'd1);
    req_val = req_after;
    loads = 0;
    cyc   = 0;
    while (trace_state == 3'd1 && cyc < 100) begin
      chk("acc_clr_once", 32'(arr_acc_clr), 32'(cyc == 0));
      chk("load_grant", 32'(req_grant), 32'(g));
      loads += int'(arr_load_en);
      cyc++;
      tick();
    end
    chk("load_beats", loads, 4);
    chk("load_cycles", cyc, 4);
    finish_from_run(g, stall_row);
  endtask

  initial begin
    logic [6:0] pat;
    int         n;
    rst      = 1'b0;
    req_val  = '0;
    load_val = 1'b0;
    out_rdy  = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk_zero("reset_state");
    rst = 1'b1;
    tick();
    chk_zero("idle_no_req");

    // single job, requester 0
    req_val  = 2'b01;
    load_val = 1'b1;
    out_rdy  = 1'b1;
    do_job(2'b01, 0, 2'b01, -1);
    req_val = '0;

    // both requesting: alternate 0,1,0,1 from a fresh pointer
    rst = 1'b0;
    #3;
    rst = 1'b1;
    req_val = 2'b11;
    do_job(2'b01, 0, 2'b11, -1);
    do_job(2'b10, 1, 2'b11, -1);
    do_job(2'b01, 0, 2'b11, -1);
    do_job(2'b10, 1, 2'b11, -1);
    req_val = '0;

    // load bubbles 1,0,0,1,1,0,1
    req_val  = 2'b01;
    load_val = 1'b0;
    tick();
    chk("bub_grant", 32'(req_grant), 32'd1);
    req_val = '0;
    pat = 7'b1011001;
    n = 0;
    for (int i = 0; i < 7; i++) begin
      load_val = pat[i];
      #1;
      chk("bub_state", 32'(trace_state), 32'd1);
      chk("bub_rdy", 32'(load_rdy), 32'd1);
      chk("bub_load_en", 32'(arr_load_en), 32'(pat[i]));
      n += int'(arr_load_en);
      tick();
    end
    chk("bub_beats", n, 4);
    chk("bub_run_start", 32'(trace_state), 32'd2);
    load_val = 1'b1;
    out_rdy  = 1'b1;
    finish_from_run(2'b01, -1);

    // output stall at row 2, requester 1 (pointer now 1)
    req_val = 2'b10;
    do_job(2'b10, 1, 2'b10, 2);
    req_val = '0;

    // async reset in the middle of RUN
    req_val = 2'b01;
    tick();
    repeat (5) tick();
    chk("mid_run_state", 32'(trace_state), 32'd2);
    chk("mid_run_mac", 32'(arr_mac_en), 32'd1);
    req_val = '0;
    #3;
    rst = 1'b0;
    #1;
    chk_zero("async_reset_midrun");
    req_val = 2'b10;
    @(posedge clk);
    #2;
    chk_zero("held_in_reset");
    rst = 1'b1;
    tick();
    chk("rel_grant_10", 32'(req_grant), 32'd2);
    chk("rel_sel_10", 32'(sel), 32'd1);
    rst = 1'b0;
    #1;
    chk_zero("reset_in_load");
    req_val = 2'b11;
    #2;
    rst = 1'b1;
    tick();
    chk("rel_grant_11", 32'(req_grant), 32'd1);
    chk("rel_sel_11", 32'(sel), 32'd0);
    rst = 1'b0;
    #3;
    rst = 1'b1;
    req_val = '0;

    // granted requester drops during LOAD, other one raises
    req_val  = 2'b01;
    load_val = 1'b1;
    out_rdy  = 1'b1;
    do_job(2'b01, 0, 2'b10, -1);
    tick();
    chk("post_drop_grant", 32'(req_grant), 32'd2);
    chk("post_drop_sel", 32'(sel), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_job_sched.md
Name: systolic_job_sched

Overview:
- Shares one systolic MAC array between NREQ requesters and sequences each job through load, compute and drain phases.
- Grants are round-robin. The block drives the array's load, MAC-enable and accumulator-clear controls, and an index that steers external x/w/result muxes.
- It sits between the requester-side request ports and the array's input buffers.

Parameters:
- NREQ, 2, number of requesters (1..8).
- SIZE, 4, array dimension: rows loaded per job and result rows drained per job.
- RUN_CYCLES, 3*SIZE-2, cycles mac_en is held after loading, covering systolic skew.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset: low clears all state immediately.
- req_val  in  NREQ  bit i high means requester i wants a job.
- req_grant  out  NREQ  one-hot grant, held for the whole job.
- sel  out  max(1,clog2(NREQ))  index of the granted requester.
- load_val  in  1  granted requester presents one x/w row pair.
- load_rdy  out  1  scheduler accepts a row pair.
- arr_load_en  out  1  write strobe to array input buffers.
- arr_acc_clr  out  1  one-cycle accumulator clear.
- arr_mac_en  out  1  array compute enable.
- out_val  out  1  result row available from the array.
- out_rdy  in  1  consumer accepts the result row.
- out_row  out  clog2(SIZE)  index of the current result row.
- job_done  out  1  one-cycle pulse at end of job.
- busy  out  1  high in any state except IDLE.
- trace_state  out  3  state encoding, for cocotb only.

Behaviour:
- Reset values: state IDLE, all outputs 0, RR pointer 0, all counters 0.
- States and encodings: IDLE=0, LOAD=1, RUN=2, OUT=3, DONE=4. All state and outputs are registered except the handshake outputs noted below.
- IDLE:
  - If any req_val is high, pick the first set bit searching upward (with wrap) from the pointer.
  - Next edge: req_grant and sel registered, arr_acc_clr=1 for exactly one cycle (the first LOAD cycle), go to LOAD.
  - No request: stay in IDLE.
- LOAD:
  - load_rdy=1 (combinational from state).
  - arr_load_en = load_val & load_rdy (combinational).
  - A beat counter counts accepted beats; bubbles on load_val simply extend LOAD.
  - On the SIZE-th accepted beat, go to RUN next edge with the counter cleared.
- RUN:
  - arr_mac_en=1 for exactly RUN_CYCLES consecutive cycles, counted by a cycle counter.
  - Then go to OUT.
- OUT:
  - arr_mac_en=0; out_val=1; out_row = row counter.
  - The counter increments on out_val & out_rdy.
  - While out_rdy is low, out_row is held and out_val stays high.
  - After the transfer with out_row=SIZE-1, go to DONE.
- DONE:
  - job_done=1 for one cycle; req_grant cleared; pointer = granted index + 1 (mod NREQ).
  - Next edge go to IDLE.
- Minimum gap between jobs is one IDLE cycle.
- Signals ignored while not meaningful:
  - load_val outside LOAD is ignored (load_rdy=0).
  - out_rdy outside OUT is ignored.
  - Dropping req_val mid-job does not abort the job; it runs to DONE. Abort is not supported.
- Non-granted req_val changes have no effect until IDLE.
- Reset mid-job: immediate return to reset values without waiting for a clock edge. The pointer returns to 0, so requester 0 has priority on release.
- Invariants:
  - At most one req_grant bit is high.
  - arr_load_en and arr_mac_en are never high together.
  - busy = (state != IDLE).
- Counters are clog2(RUN_CYCLES+1) bits wide and must not wrap inside a phase.

Decomposition:
- systolic_pkg:
  - state enum (3-bit, encodings above).
  - Function run_cycles(size).
  - Localparam for the sel width.
- One sub-module, systolic_rr_arb:
  - Combinational round-robin pick from a req vector and pointer.
  - Outputs a one-hot grant and an index.
  - The pointer register stays in systolic_job_sched.

Test Plan:
- Single job, SIZE=4, req_val=01, load_val always high:
  - Grant to 0 the edge after request; arr_acc_clr 1 cycle.
  - 4 arr_load_en beats.
  - arr_mac_en high exactly 10 cycles.
  - out_row 0,1,2,3 on consecutive cycles.
  - job_done pulse, then IDLE.
- req_val=11 held continuously through 4 jobs:
  - Grants alternate 0,1,0,1.
  - sel matches the grant each job.
- load_val pattern 1,0,0,1,1,0,1:
  - Exactly 4 arr_load_en pulses.
  - LOAD lasts 7 cycles.
  - RUN starts the edge after the 4th beat.
- out_rdy low for 3 cycles when out_row=2:
  - out_val stays 1 and out_row stays 2 during the stall.
  - Row 3 follows after out_rdy rises.
  - job_done comes 1 cycle after the row-3 transfer.
- rst driven low mid-RUN, asserted between clock edges:
  - All outputs 0 before the next edge.
  - After release with req_val=10: grant to 1.
  - After release with req_val=11: grant to 0.
- Granted requester drops req_val during LOAD:
  - Job completes fully with all 4 out rows.
  - No grant change until DONE.
